// File: rtl/routing_pkg.sv
// routing_pkg: shared defaults, width helper and record types for the routing blocks
package routing_pkg;

    localparam int S_DEFAULT = 3;
    localparam int T_DEFAULT = 1;

    // Index width for v entries, never narrower than one bit
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // Output slot record for the default channel configuration
    typedef struct packed {
        logic [T_DEFAULT-1:0] data;
        logic                 last;
        logic [S_DEFAULT-1:0] sel;
        logic                 valid;
    } slot_t;

    typedef enum logic {
        IDLE,
        LOCKED
    } lock_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above ptr
module rr_arbiter
    import routing_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]          req,
    input  logic [clog2(N)-1:0]   ptr,
    output logic [N-1:0]          grant,
    output logic [clog2(N)-1:0]   idx
);

    localparam int W = clog2(N);

    logic [W-1:0] k;
    logic         found;

    // Walk the channels from ptr upward, wrapping at N, and keep the first requester
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        k     = '0;
        for (int i = 0; i < N; i++) begin
            k = W'((int'(ptr) + i) % N);
            if (!found && req[k]) begin
                found    = 1'b1;
                grant[k] = 1'b1;
                idx      = k;
            end
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: registered 2^S-channel valid/ready stream mux, round-robin or forced select; packet lock under RR_STREAM_MUX_LOCK_EN
module rr_stream_mux
    import routing_pkg::*;
#(
    parameter int S = S_DEFAULT,
    parameter int T = T_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [S-1:0]          ctrl,
    input  logic                  force_sel,
    input  logic [(2**S)*T-1:0]   in,
    input  logic [2**S-1:0]       in_valid,
    input  logic [2**S-1:0]       in_last,
    output logic [2**S-1:0]       in_ready,
    output logic [T-1:0]          out,
    output logic                  out_valid,
    output logic                  out_last,
    output logic [S-1:0]          out_sel,
    input  logic                  out_ready
);

    localparam int N = 2**S;

    typedef struct packed {
        logic [T-1:0] data;
        logic         last;
        logic [S-1:0] sel;
        logic         valid;
    } mux_slot_t;

    mux_slot_t    slot;
    logic [S-1:0] rr_ptr;
    logic [S-1:0] idx;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic         can_load;
    logic         xfer;
    logic         advance;

`ifdef RR_STREAM_MUX_LOCK_EN
    lock_state_e  state, state_n;
    logic [S-1:0] lock_ch, lock_ch_n;
    logic         locked;

    // A held packet owns the grant, overriding both round-robin and forced select
    assign locked  = state == LOCKED;
    assign req     = locked    ? (in_valid & (N'(1) << lock_ch)) :
                     force_sel ? (in_valid & (N'(1) << ctrl))    : in_valid;
    assign advance = in_last[idx];

    // Lock state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            lock_ch <= '0;
        end else begin
            state   <= state_n;
            lock_ch <= lock_ch_n;
        end
    end

    // Every beat re-decides the lock: a non-last beat holds its channel, a last beat frees it
    always_comb begin
        state_n   = state;
        lock_ch_n = lock_ch;
        if (xfer) begin
            state_n   = in_last[idx] ? IDLE : LOCKED;
            lock_ch_n = idx;
        end
    end
`else
    assign req     = force_sel ? (in_valid & (N'(1) << ctrl)) : in_valid;
    assign advance = 1'b1;
`endif

    rr_arbiter #(.N(N)) u_arb (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (idx)
    );

    // Ready follows out_ready combinationally so a draining slot can refill in the same cycle
    assign can_load  = !slot.valid || out_ready;
    assign in_ready  = (can_load && !rst) ? grant : '0;
    assign xfer      = |in_ready;

    assign out       = slot.data;
    assign out_last  = slot.last;
    assign out_sel   = slot.sel;
    assign out_valid = slot.valid;

    // Output slot and round-robin pointer; slot contents only change on a load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot   <= '0;
            rr_ptr <= '0;
        end else begin
            if (xfer)
                slot <= '{data: in[int'(idx)*T +: T], last: in_last[idx], sel: idx, valid: 1'b1};
            else if (out_ready)
                slot.valid <= 1'b0;
            if (xfer && advance)
                rr_ptr <= idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux: directed and random checks of rr_stream_mux (S=2, T=8) against a behavioural model
module tb_rr_stream_mux;

`ifdef RR_STREAM_MUX_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ctrl;
    logic        force_sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_last;
    logic [3:0]  in_ready;
    logic [7:0]  out;
    logic        out_valid;
    logic        out_last;
    logic [1:0]  out_sel;
    logic        out_ready;

    int nvec = 0;
    int errs = 0;

    int         m_ptr;
    int         m_lch;
    bit         m_locked;
    bit         m_sv;
    bit         m_sl;
    logic [7:0] m_sd;
    int         m_ss;

    rr_stream_mux #(.S(2), .T(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .ctrl      (ctrl),
        .force_sel (force_sel),
        .in        (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        chk("out", 32'(out), 32'(m_sd));
        chk("out_valid", 32'(out_valid), 32'(m_sv));
        chk("out_last", 32'(out_last), 32'(m_sl));
        chk("out_sel", 32'(out_sel), 32'(m_ss));
    endtask

    task automatic model_reset();
        m_sv = 0; m_sl = 0; m_sd = '0; m_ss = 0; m_ptr = 0; m_locked = 0; m_lch = 0;
    endtask

    // One cycle: drive, check against the model, advance the model, cross the edge
    task automatic step(input logic [3:0] v, input logic [3:0] l, input bit ordy, input bit fs, input logic [1:0] c);
        int g;
        bit can;
        logic [3:0] er;
        in_valid = v; in_last = l; out_ready = ordy; force_sel = fs; ctrl = c;
        #1;
        g = -1;
        if (LOCK_EN && m_locked) g = v[m_lch] ? m_lch : -1;
        else if (fs) g = v[c] ? int'(c) : -1;
        else for (int i = 0; i < 4; i++) if (g < 0 && v[(m_ptr + i) % 4]) g = (m_ptr + i) % 4;
        can = !m_sv || ordy;
        er = (can && g >= 0) ? 4'(1 << g) : 4'b0;
        chk("in_ready", 32'(in_ready), 32'(er));
        check_out();
        if (can && g >= 0) begin
            m_sd = in_data[g*8 +: 8];
            m_sl = l[g];
            m_ss = g;
            m_sv = 1;
            if (!LOCK_EN || l[g]) m_ptr = (g + 1) % 4;
            if (LOCK_EN) begin
                m_locked = !l[g];
                m_lch = g;
            end
        end else if (ordy) m_sv = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_out();
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        check_out();
        chk("rst_in_ready_hold", 32'(in_ready), 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ctrl = '0; force_sel = 1'b0; in_data = 32'hD3C2B1A0;
        in_valid = 4'hF; in_last = 4'hF; out_ready = 1'b1;
        @(posedge clk);
        #1;
        do_reset();
        // round-robin, full throughput
        for (int i = 0; i < 6; i++) step(4'hF, 4'hF, 1'b1, 1'b0, 2'd0);
        // backpressure then release
        in_data = 32'h55555555;
        for (int i = 0; i < 3; i++) step(4'hF, 4'hF, 1'b0, 1'b0, 2'd0);
        in_data = 32'h44332211;
        for (int i = 0; i < 3; i++) step(4'hF, 4'hF, 1'b1, 1'b0, 2'd0);
        // forced select, then forced channel idle
        step(4'hF, 4'hF, 1'b1, 1'b1, 2'd2);
        step(4'hF, 4'hF, 1'b1, 1'b1, 2'd2);
        step(4'b1011, 4'hF, 1'b1, 1'b1, 2'd2);
        step(4'b1011, 4'hF, 1'b1, 1'b1, 2'd2);
        // pointer at 3, sparse request wraps to channel 1, then pointer at 2
        step(4'b0010, 4'hF, 1'b1, 1'b0, 2'd0);
        step(4'b0101, 4'hF, 1'b1, 1'b0, 2'd0);
        // reset with a beat held in the slot
        step(4'hF, 4'hF, 1'b0, 1'b0, 2'd0);
        step(4'hF, 4'hF, 1'b0, 1'b0, 2'd0);
        do_reset();
        // three-beat packet on channel 1 competing with channel 2
        in_data = 32'h40302010;
        step(4'b0110, 4'b0000, 1'b1, 1'b0, 2'd0);
        step(4'b0110, 4'b0000, 1'b1, 1'b0, 2'd0);
        step(4'b0110, 4'b0010, 1'b1, 1'b0, 2'd0);
        step(4'b0110, 4'b0110, 1'b1, 1'b0, 2'd0);
        step(4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            in_data = $urandom;
            step(4'($urandom), 4'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 2'($urandom));
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule

// File: doc/rr_stream_mux.md
# rr_stream_mux

Registered 2^S-channel stream multiplexer with valid/ready handshakes and round-robin arbitration; each channel carries T bits. It is the sequential successor of the combinational select tree in `routing/`. It adds a fixed-select mode driven by `ctrl`, backpressure, a one-beat output register, and optional packet locking. It sits between several producers and one shared consumer, such as a bus port or a FIFO.

## Interface
- S, 3, select width; channel count N = 2^S (S ≥ 1)
- T, 1, data width per channel
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ctrl  in  S  fixed channel index, used when `force_sel`=1
- force_sel  in  1  1: only channel `ctrl` may be granted; 0: round-robin
- in  in  N*T  channel k data = in[(k+1)*T-1 : k*T]
- in_valid  in  N  per-channel valid
- in_last  in  N  per-channel end-of-packet flag
- in_ready  out  N  per-channel ready (one-hot or zero)
- out  out  T  registered data
- out_valid  out  1  registered valid
- out_last  out  1  registered last
- out_sel  out  S  index of the channel that produced the current `out`
- out_ready  in  1  consumer ready

## Operation
- Output stage is a single register slot holding `out`, `out_last`, `out_sel` and `out_valid`.
- The slot can load when `can_load` = !out_valid || out_ready.
- **Grant selection (combinational):**
  - Round-robin mode: the first channel with in_valid=1, searching from `rr_ptr` upward modulo N.
  - `force_sel`=1: grant = `ctrl` if in_valid[ctrl]=1, else no grant.
- in_ready[g] = can_load for the granted channel g; all other bits are 0.
- A transfer on channel g happens when in_valid[g] && in_ready[g]. On a transfer, the slot loads in[g], in_last[g] and g, and out_valid is set to 1.
- Slot drain: out_valid && out_ready with no new load clears out_valid to 0.
- Simultaneous drain and load is a full-throughput beat: the slot is replaced and out_valid stays 1.
- `rr_ptr` update: after each transfer, rr_ptr = (g+1) mod N, wrapping from N-1 to 0. It is also updated in forced mode.
- Data path holds: `out`, `out_last` and `out_sel` hold their value while out_valid && !out_ready.
- Reset values: out=0, out_last=0, out_sel=0, out_valid=0, rr_ptr=0, lock state cleared. in_ready is 0 during reset.
- Reset mid-packet: the slot is discarded and the lock is released. No partial beat is emitted after rst falls.

## Timing
- Latency: an input accepted at edge n appears on `out` with out_valid=1 after edge n; one cycle latency.
- Throughput: 1 beat/cycle when out_ready is held at 1.
- No combinational path from in_valid or in_last to any out* signal.
- A combinational path from out_ready to in_ready exists by design.
- Switching `force_sel` or `ctrl` takes effect on the next grant evaluation. It never corrupts a beat already in the slot.

## Configuration
- `RR_STREAM_MUX_LOCK_EN` defined:
  - After a transfer with in_last=0, the grant is locked to that channel until a transfer with in_last=1 on it.
  - While locked, other channels get in_ready=0, and `force_sel`/`ctrl` are ignored.
  - rr_ptr advances only on the last beat.
- Not defined: arbitration happens on every beat, and in_last is passed through as data only.

## Structure
- Shared package `routing_pkg`:
  - `clog2`-style helper.
  - Default values for S and T.
  - Typedef for the output slot record (data, last, sel, valid).
- One sub-module, `rr_arbiter` (parameter N):
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant and its encoded index.
  - Purely combinational and reusable by other routing blocks.
- The top module holds the slot register, rr_ptr and the lock FSM.
- Lock FSM states: IDLE and LOCKED(channel).
  - IDLE → LOCKED on a transfer with in_last=0.
  - LOCKED → IDLE on a transfer with in_last=1.

## Test plan
Configuration for all scenarios: S=2, T=8.
- Reset: assert rst mid-stream with out_valid=1 → all outputs 0 immediately, and in_ready=0000 while rst=1.
- Round-robin: in_valid=1111 held, out_ready=1, last=1 on every beat → out_sel sequence 0,1,2,3,0 with data 0xA0,0xB1,0xC2,0xD3,0xA0, one beat per cycle.
- Backpressure: hold out_ready=0 for 3 cycles with out_valid=1 and out=0x55 → out stable at 0x55, in_ready=0000. Then release → no beat lost or duplicated.
- Forced select: force_sel=1, ctrl=2, in_valid=1111 → only channel 2 is granted (in_ready=0100). Then ctrl=2 with in_valid[2]=0 → no transfer, out_valid drops to 0 after drain.
- Lock (macro defined): channel 1 sends 3 beats with last on the 3rd, while channel 2 is valid throughout → out_sel=1,1,1 then 2. Without the macro → out_sel alternates 1,2,1,2.
- Wrap and sparse requests: rr_ptr=3, in_valid=0010 → grant channel 1, then rr_ptr=2.
